// File: rtl/systolic_mm_scheduler.sv
// Round-robin scheduler sharing one S x S systolic matrix-multiply array
// between two requesters; sequences clear/run/capture and latches the result.
//
// Ports:
//   clk                    rising-edge clock
//   rst                    asynchronous active-low reset
//   req[1:0]               level job requests, sampled only while idle
//   cfg0[1:0], cfg1[1:0]   per-requester {sel1,sel2} operand select codes
//   ack[1:0]               one-cycle grant pulse in the first clear cycle
//   done[1:0]              one-cycle completion pulse, res_data valid with it
//   busy                   high from first clear cycle through capture
//   arr_rst                active-high array clear
//   arr_sel1, arr_sel2     array operand selects, change only on a grant
//   arr_data               array result bus, S*S elements of M bits
//   res_data               captured result, held until the next capture
//   res_owner              requester index of the last completed job
module systolic_mm_scheduler #(
   parameter int S       = 4,
   parameter int N       = 2,
   parameter int M       = 6,
   parameter int CLR_CYC = 2,
   parameter int LAT     = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [1:0]       cfg0,
   input  logic [1:0]       cfg1,
   output logic [1:0]       ack,
   output logic [1:0]       done,
   output logic             busy,
   output logic             arr_rst,
   output logic             arr_sel1,
   output logic             arr_sel2,
   input  logic [S*S*M-1:0] arr_data,
   output logic [S*S*M-1:0] res_data,
   output logic             res_owner
);

   // One counter serves both the clear and run phases.
   localparam int CMAX = (LAT > CLR_CYC) ? LAT : CLR_CYC;
   localparam int CW   = $clog2(CMAX + 1);

   if (CLR_CYC < 1 || LAT < 1 || N < 1 || S < 1 || M < 1) begin : g_bad_param
      $error("systolic_mm_scheduler: illegal parameter value");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_CAPTURE
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nx;
   logic               r_ptr;
   logic               w_ptr_nx;
   logic               r_owner;
   logic               w_owner_nx;
   logic               r_sel1;
   logic               w_sel1_nx;
   logic               r_sel2;
   logic               w_sel2_nx;
   logic [1:0]         r_ack;
   logic [1:0]         w_ack_nx;
   logic [1:0]         r_done;
   logic [1:0]         w_done_nx;
   logic               r_busy;
   logic               w_busy_nx;
   logic               r_arr_rst;
   logic               w_arr_rst_nx;
   logic               r_res_owner;
   logic               w_res_owner_nx;
   logic [S*S*M-1:0]   r_res;
   logic               w_cap;
   logic               w_gnt;

   // Contention goes to the pointer side; otherwise the lone requester.
   assign w_gnt = (req == 2'b11) ? r_ptr : req[1];

   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_ptr_nx       = r_ptr;
      w_owner_nx     = r_owner;
      w_sel1_nx      = r_sel1;
      w_sel2_nx      = r_sel2;
      w_ack_nx       = 2'b00;
      w_done_nx      = 2'b00;
      w_busy_nx      = 1'b0;
      w_arr_rst_nx   = 1'b1;
      w_res_owner_nx = r_res_owner;
      w_cap          = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (req != 2'b00) begin
               w_state_nx = ST_CLEAR;
               w_cnt_nx   = '0;
               w_owner_nx = w_gnt;
               w_ptr_nx   = ~w_gnt;
               w_ack_nx   = w_gnt ? 2'b10 : 2'b01;
               w_busy_nx  = 1'b1;
               if (w_gnt) begin
                  w_sel1_nx = cfg1[1];
                  w_sel2_nx = cfg1[0];
               end else begin
                  w_sel1_nx = cfg0[1];
                  w_sel2_nx = cfg0[0];
               end
            end
         end
         ST_CLEAR: begin
            w_busy_nx = 1'b1;
            if (r_cnt == CW'(CLR_CYC - 1)) begin
               w_state_nx   = ST_RUN;
               w_cnt_nx     = '0;
               w_arr_rst_nx = 1'b0;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            w_busy_nx    = 1'b1;
            w_arr_rst_nx = 1'b0;
            if (r_cnt == CW'(LAT - 1)) begin
               w_state_nx = ST_CAPTURE;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         ST_CAPTURE: begin
            // Data bus is sampled at the end of this cycle; done lands
            // in the following idle cycle alongside the new result.
            w_state_nx     = ST_IDLE;
            w_cap          = 1'b1;
            w_res_owner_nx = r_owner;
            w_done_nx      = r_owner ? 2'b10 : 2'b01;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_ptr       <= 1'b0;
         r_owner     <= 1'b0;
         r_sel1      <= 1'b0;
         r_sel2      <= 1'b0;
         r_ack       <= 2'b00;
         r_done      <= 2'b00;
         r_busy      <= 1'b0;
         r_arr_rst   <= 1'b1;
         r_res_owner <= 1'b0;
         r_res       <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_ptr       <= w_ptr_nx;
         r_owner     <= w_owner_nx;
         r_sel1      <= w_sel1_nx;
         r_sel2      <= w_sel2_nx;
         r_ack       <= w_ack_nx;
         r_done      <= w_done_nx;
         r_busy      <= w_busy_nx;
         r_arr_rst   <= w_arr_rst_nx;
         r_res_owner <= w_res_owner_nx;
         if (w_cap) begin
            r_res <= arr_data;
         end
      end
   end

   assign ack       = r_ack;
   assign done      = r_done;
   assign busy      = r_busy;
   assign arr_rst   = r_arr_rst;
   assign arr_sel1  = r_sel1;
   assign arr_sel2  = r_sel2;
   assign res_data  = r_res;
   assign res_owner = r_res_owner;

endmodule
